// File: rtl/inst_seq_pkg.sv
// Shared field positions, idle instruction word and FSM states for inst_sequencer.
package inst_seq_pkg;

  localparam int INST_W = 34;

  localparam int B_ACC      = 33;
  localparam int B_CEN_P    = 32;
  localparam int B_WEN_P    = 31;
  localparam int B_A_P      = 20;
  localparam int B_CEN_X    = 19;
  localparam int B_WEN_X    = 18;
  localparam int B_A_X      = 7;
  localparam int B_OFIFO_RD = 6;
  localparam int B_IFIFO_WR = 5;
  localparam int B_IFIFO_RD = 4;
  localparam int B_L0_RD    = 3;
  localparam int B_L0_WR    = 2;
  localparam int B_EXEC     = 1;
  localparam int B_LOAD     = 0;

  // Both SRAMs disabled (active-low CEN/WEN high), every strobe and address zero.
  localparam logic [INST_W-1:0] IDLE_WORD = 34'h1_800C_0000;

  typedef enum logic [2:0] {
    IDLE,
    W_L0,
    W_LOAD,
    W_GAP,
    A_L0,
    EXEC,
    DRAIN,
    DONE
  } state_e;

endpackage

// File: rtl/inst_sequencer_xmem_l0_mover.sv
// xmem -> L0 streaming reader: issues i_len reads from i_base, then one trailing
// cycle so the l0_wr that follows the last read (SRAM latency 1) can complete.
module xmem_l0_mover #(
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_go,
  input  logic [ADDR_W-1:0] i_base,
  input  logic [ADDR_W-1:0] i_len,
  output logic [ADDR_W-1:0] o_a_xmem,
  output logic              o_cen_xmem,
  output logic              o_l0_wr,
  output logic              o_last
);

  logic [ADDR_W-1:0] r_cnt;
  logic              r_rd_d;
  logic              w_rd;

  assign w_rd       = i_go && (r_cnt < i_len);
  assign o_cen_xmem = !w_rd;
  assign o_a_xmem   = w_rd ? (i_base + r_cnt) : '0;
  assign o_l0_wr    = r_rd_d;
  assign o_last     = i_go && (r_cnt == i_len);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt  <= '0;
      r_rd_d <= 1'b0;
    end else begin
      r_rd_d <= w_rd;
      if (i_go && !o_last) r_cnt <= r_cnt + ADDR_W'(1);
      else                 r_cnt <= '0;
    end
  end

endmodule

// File: rtl/inst_sequencer.sv
// Single-tile convolution instruction sequencer for the systolic core.
// Optional accumulate-into-pmem support is enabled with `INST_SEQ_ACC_EN.
//
// state  | meaning
// IDLE   | idle word, waiting for start
// W_L0   | weights xmem -> L0 (COL reads + 1 trailing l0_wr)
// W_LOAD | kernel load into PE array, COL cycles
// W_GAP  | idle word for LOAD_GAP cycles while weights settle
// A_L0   | activations xmem -> L0 (ACT_LEN reads + 1 trailing l0_wr)
// EXEC   | execute, ACT_LEN cycles
// DRAIN  | OFIFO rows -> pmem until ACT_LEN writes issued
// DONE   | one-cycle completion, done pulse
module inst_sequencer
  import inst_seq_pkg::*;
#(
  parameter int ADDR_W   = 11,
  parameter int COL      = 8,
  parameter int ACT_LEN  = 36,
  parameter int LOAD_GAP = 16,
  parameter int W_BASE   = 0,
  parameter int A_BASE   = 64,
  parameter int P_BASE   = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              ofifo_valid,
`ifdef INST_SEQ_ACC_EN
  input  logic              acc_mode,
`endif
  output logic [INST_W-1:0] inst,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LP_COL     = ADDR_W'(COL);
  localparam logic [ADDR_W-1:0] LP_COL_M1  = ADDR_W'(COL - 1);
  localparam logic [ADDR_W-1:0] LP_ACT     = ADDR_W'(ACT_LEN);
  localparam logic [ADDR_W-1:0] LP_ACT_M1  = ADDR_W'(ACT_LEN - 1);
  localparam logic [ADDR_W-1:0] LP_GAP_M1  = ADDR_W'(LOAD_GAP - 1);
  localparam logic [ADDR_W-1:0] LP_W_BASE  = ADDR_W'(W_BASE);
  localparam logic [ADDR_W-1:0] LP_A_BASE  = ADDR_W'(A_BASE);
  localparam logic [ADDR_W-1:0] LP_P_BASE  = ADDR_W'(P_BASE);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [ADDR_W-1:0] r_tmr;
  logic              w_tmr_load;
  logic [ADDR_W-1:0] w_tmr_val;
  logic [ADDR_W-1:0] r_rd_cnt;
  logic [ADDR_W-1:0] r_wr_cnt;
  logic              r_rd_pend;
  logic              w_rd;
  logic              w_wr;
  logic [INST_W-1:0] w_word;
  logic [INST_W-1:0] r_inst;
  logic              r_busy;
  logic              r_done;

  logic              w_go;
  logic [ADDR_W-1:0] w_base;
  logic [ADDR_W-1:0] w_len;
  logic [ADDR_W-1:0] w_a_x;
  logic              w_cen_x;
  logic              w_l0_wr;
  logic              w_last;

  assign w_go   = (r_state == W_L0) || (r_state == A_L0);
  assign w_base = (r_state == A_L0) ? LP_A_BASE : LP_W_BASE;
  assign w_len  = (r_state == A_L0) ? LP_ACT    : LP_COL;

  xmem_l0_mover #(
    .ADDR_W (ADDR_W)
  ) u_mover (
    .clk        (clk),
    .reset      (reset),
    .i_go       (w_go),
    .i_base     (w_base),
    .i_len      (w_len),
    .o_a_xmem   (w_a_x),
    .o_cen_xmem (w_cen_x),
    .o_l0_wr    (w_l0_wr),
    .o_last     (w_last)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_word      = IDLE_WORD;
    w_tmr_load  = 1'b0;
    w_tmr_val   = '0;
    w_rd        = 1'b0;
    w_wr        = 1'b0;
    case (r_state)
      // A start landing on the done cycle must not relaunch the pass.
      IDLE: if (start && !r_done) w_state_nxt = W_L0;
      W_L0, A_L0: begin
        w_word[B_CEN_X]          = w_cen_x;
        w_word[B_A_X +: ADDR_W]  = w_a_x;
        w_word[B_L0_WR]          = w_l0_wr;
        if (w_last) begin
          w_tmr_load = 1'b1;
          if (r_state == W_L0) begin
            w_state_nxt = W_LOAD;
            w_tmr_val   = LP_COL_M1;
          end else begin
            w_state_nxt = EXEC;
            w_tmr_val   = LP_ACT_M1;
          end
        end
      end
      W_LOAD: begin
        w_word[B_L0_RD] = 1'b1;
        w_word[B_LOAD]  = 1'b1;
        if (r_tmr == '0) begin
          w_state_nxt = W_GAP;
          w_tmr_load  = 1'b1;
          w_tmr_val   = LP_GAP_M1;
        end
      end
      W_GAP: if (r_tmr == '0) w_state_nxt = A_L0;
      EXEC: begin
        w_word[B_L0_RD] = 1'b1;
        w_word[B_EXEC]  = 1'b1;
        if (r_tmr == '0) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        w_rd = ofifo_valid && (r_rd_cnt < LP_ACT);
        w_wr = r_rd_pend;
        w_word[B_OFIFO_RD] = w_rd;
        if (w_wr) begin
          w_word[B_CEN_P]         = 1'b0;
          w_word[B_WEN_P]         = 1'b0;
          w_word[B_A_P +: ADDR_W] = LP_P_BASE + r_wr_cnt;
`ifdef INST_SEQ_ACC_EN
          w_word[B_ACC]           = acc_mode;
`endif
          if (r_wr_cnt == LP_ACT_M1) w_state_nxt = DONE;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_tmr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_tmr_load)        r_tmr <= w_tmr_val;
      else if (r_tmr != '0)  r_tmr <= r_tmr - ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_cnt  <= '0;
      r_wr_cnt  <= '0;
      r_rd_pend <= 1'b0;
    end else if (r_state != DRAIN) begin
      r_rd_cnt  <= '0;
      r_wr_cnt  <= '0;
      r_rd_pend <= 1'b0;
    end else begin
      r_rd_pend <= w_rd;
      if (w_rd) r_rd_cnt <= r_rd_cnt + ADDR_W'(1);
      if (w_wr) r_wr_cnt <= r_wr_cnt + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_inst <= IDLE_WORD;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_inst <= w_word;
      r_busy <= (r_state != IDLE);
      r_done <= (r_state == DONE);
    end
  end

  assign inst = r_inst;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_inst_sequencer.sv
// Directed bench for inst_sequencer: captures whole passes and checks each word
// against hand-derived expectations for the default parameter set.
module tb_inst_sequencer;

  localparam logic [33:0] IDLE_W = 34'h1_800C_0000;
  localparam int NCAP = 200;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        ofifo_valid;
`ifdef INST_SEQ_ACC_EN
  logic        acc_mode;
`endif
  logic [33:0] inst;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_pass   = 0;
  bit exp_acc  = 1'b0;

  logic [33:0] cap_inst [0:NCAP-1];
  logic        cap_busy [0:NCAP-1];
  logic        cap_done [0:NCAP-1];

  always #5 clk = ~clk;

  inst_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .ofifo_valid (ofifo_valid),
`ifdef INST_SEQ_ACC_EN
    .acc_mode    (acc_mode),
`endif
    .inst        (inst),
    .busy        (busy),
    .done        (done)
  );

  function automatic logic [33:0] mk(input bit rd_x, input int a_x, input bit l0wr,
                                     input bit l0rd, input bit ld, input bit ex,
                                     input bit ofr, input bit wp, input int a_p,
                                     input bit acc);
    logic [33:0] w;
    logic [31:0] ax;
    logic [31:0] ap;
    ax = a_x;
    ap = a_p;
    w = '0;
    w[33]    = acc;
    w[32]    = ~wp;
    w[31]    = ~wp;
    w[30:20] = ap[10:0];
    w[19]    = ~rd_x;
    w[18]    = 1'b1;
    w[17:7]  = ax[10:0];
    w[6]     = ofr;
    w[3]     = l0rd;
    w[2]     = l0wr;
    w[1]     = ex;
    w[0]     = ld;
    return w;
  endfunction

  // Sample j is taken after the edge that sampled start plus j cycles; the
  // ofifo_valid driven after sample j is seen by the state producing word j+1.
  task automatic run_pass(input int mid_at, input int late_at);
    @(negedge clk);
    start = 1'b1;
    ofifo_valid = 1'b0;
    for (int j = 0; j < NCAP; j++) begin
      @(negedge clk);
      cap_inst[j] = inst;
      cap_busy[j] = busy;
      cap_done[j] = done;
      start = (j == mid_at) || (j == late_at);
      ofifo_valid = (((j + 1) % 2) == 1);
    end
    start = 1'b0;
    ofifo_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start = 1'b0;
    ofifo_valid = 1'b0;
`ifdef INST_SEQ_ACC_EN
    acc_mode = 1'b0;
`endif
    #23;
    n_checks++;
    if (inst !== IDLE_W) $display("FAIL reset_inst got=%h exp=%h", inst, IDLE_W);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy);
    else n_pass++;
    n_checks++;
    if (done !== 1'b0) $display("FAIL reset_done got=%b exp=0", done);
    else n_pass++;
    @(negedge clk);
    reset = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      n_checks++;
      if (inst !== IDLE_W || busy !== 1'b0) $display("FAIL post_reset_idle[%0d] inst=%h busy=%b exp=%h/0", j, inst, busy, IDLE_W);
      else n_pass++;
    end
  endtask

  task automatic test_weight_transfer();
    logic [33:0] e;
    run_pass(-1, -1);
    n_checks++;
    if (cap_inst[0] !== IDLE_W || cap_busy[0] !== 1'b0) $display("FAIL wt_first_cycle inst=%h busy=%b exp=%h/0", cap_inst[0], cap_busy[0], IDLE_W);
    else n_pass++;
    n_checks++;
    if (cap_busy[1] !== 1'b1) $display("FAIL wt_busy_rise got=%b exp=1", cap_busy[1]);
    else n_pass++;
    for (int k = 0; k <= 8; k++) begin
      e = mk(k < 8, (k < 8) ? k : 0, k >= 1, 0, 0, 0, 0, 0, 0, 0);
      n_checks++;
      if (cap_inst[1 + k] !== e) $display("FAIL w_l0[%0d] got=%h exp=%h", k, cap_inst[1 + k], e);
      else n_pass++;
    end
    e = mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    for (int j = 10; j <= 17; j++) begin
      n_checks++;
      if (cap_inst[j] !== e) $display("FAIL w_load[%0d] got=%h exp=%h", j, cap_inst[j], e);
      else n_pass++;
    end
    for (int j = 18; j <= 33; j++) begin
      n_checks++;
      if (cap_inst[j] !== IDLE_W) $display("FAIL w_gap[%0d] got=%h exp=%h", j, cap_inst[j], IDLE_W);
      else n_pass++;
    end
  endtask

  task automatic test_act_exec();
    logic [33:0] e;
    int overlap;
    run_pass(-1, -1);
    for (int k = 0; k <= 36; k++) begin
      e = mk(k < 36, (k < 36) ? (64 + k) : 0, k >= 1, 0, 0, 0, 0, 0, 0, 0);
      n_checks++;
      if (cap_inst[34 + k] !== e) $display("FAIL a_l0[%0d] got=%h exp=%h", k, cap_inst[34 + k], e);
      else n_pass++;
    end
    e = mk(0, 0, 0, 1, 0, 1, 0, 0, 0, 0);
    for (int j = 71; j <= 106; j++) begin
      n_checks++;
      if (cap_inst[j] !== e) $display("FAIL exec[%0d] got=%h exp=%h", j, cap_inst[j], e);
      else n_pass++;
    end
    overlap = 0;
    for (int j = 0; j < NCAP; j++) if (cap_inst[j][0] && cap_inst[j][1]) overlap++;
    n_checks++;
    if (overlap !== 0) $display("FAIL load_exec_overlap got=%0d exp=0", overlap);
    else n_pass++;
  endtask

  task automatic check_drain(input string tag);
    logic [33:0] e;
    int off;
    int nrd;
    int ndone;
    nrd = 0;
    for (int j = 107; j <= 178; j++) begin
      off = j - 107;
      e = mk(0, 0, 0, 0, 0, 0, (off % 2) == 0, (off % 2) == 1,
             ((off % 2) == 1) ? (off / 2) : 0, ((off % 2) == 1) && exp_acc);
      n_checks++;
      if (cap_inst[j] !== e) $display("FAIL %s drain[%0d] got=%h exp=%h", tag, off, cap_inst[j], e);
      else n_pass++;
    end
    for (int j = 0; j < NCAP; j++) if (cap_inst[j][6]) nrd++;
    n_checks++;
    if (nrd !== 36) $display("FAIL %s ofifo_rd_count got=%0d exp=36", tag, nrd);
    else n_pass++;
    ndone = 0;
    for (int j = 0; j < NCAP; j++) if (cap_done[j]) ndone++;
    n_checks++;
    if (ndone !== 1 || cap_done[179] !== 1'b1) $display("FAIL %s done_pulse count=%0d at179=%b exp=1/1", tag, ndone, cap_done[179]);
    else n_pass++;
    n_checks++;
    if (cap_busy[179] !== 1'b1 || cap_busy[180] !== 1'b0) $display("FAIL %s busy_fall b179=%b b180=%b exp=1/0", tag, cap_busy[179], cap_busy[180]);
    else n_pass++;
  endtask

  task automatic test_drain();
    exp_acc = 1'b0;
    run_pass(-1, -1);
    check_drain("drain");
    for (int j = 179; j < NCAP; j++) begin
      n_checks++;
      if (cap_inst[j] !== IDLE_W) $display("FAIL post_done_idle[%0d] got=%h exp=%h", j, cap_inst[j], IDLE_W);
      else n_pass++;
    end
  endtask

  task automatic test_accumulate();
    int nacc;
    int nacc_bad;
`ifdef INST_SEQ_ACC_EN
    acc_mode = 1'b1;
    exp_acc = 1'b1;
`else
    exp_acc = 1'b0;
`endif
    run_pass(-1, -1);
    check_drain("acc");
    nacc = 0;
    nacc_bad = 0;
    for (int j = 0; j < NCAP; j++) begin
      if (cap_inst[j][33]) begin
        nacc++;
        if (cap_inst[j][32]) nacc_bad++;
      end
    end
    n_checks++;
    if (nacc !== (exp_acc ? 36 : 0) || nacc_bad !== 0) $display("FAIL acc_bit_count got=%0d off_write=%0d exp=%0d/0", nacc, nacc_bad, exp_acc ? 36 : 0);
    else n_pass++;
`ifdef INST_SEQ_ACC_EN
    acc_mode = 1'b0;
`endif
    exp_acc = 1'b0;
  endtask

  task automatic test_ignored_start();
    int nbusy;
    run_pass(50, 179);
    check_drain("ign");
    nbusy = 0;
    for (int j = 180; j < NCAP; j++) if (cap_busy[j]) nbusy++;
    n_checks++;
    if (nbusy !== 0) $display("FAIL start_on_done_restart busy_cycles=%0d exp=0", nbusy);
    else n_pass++;
  endtask

  task automatic test_abort();
    int nbad;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int j = 1; j <= 80; j++) @(negedge clk);
    n_checks++;
    if (inst[1] !== 1'b1) $display("FAIL abort_in_exec execute=%b exp=1", inst[1]);
    else n_pass++;
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if (inst !== IDLE_W) $display("FAIL abort_inst got=%h exp=%h", inst, IDLE_W);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) $display("FAIL abort_flags busy=%b done=%b exp=0/0", busy, done);
    else n_pass++;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    nbad = 0;
    for (int j = 0; j < 60; j++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0 || inst !== IDLE_W) nbad++;
    end
    n_checks++;
    if (nbad !== 0) $display("FAIL abort_quiet bad_cycles=%0d exp=0", nbad);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    run_pass(-1, -1);
    check_drain("b2b");
    n_checks++;
    if (cap_inst[1] !== mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0)) $display("FAIL b2b_first_word got=%h exp=%h", cap_inst[1], mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_weight_transfer();
    test_act_exec();
    test_drain();
    test_accumulate();
    test_ignored_start();
    test_abort();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time_limit reached passed=%0d total=%0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/inst_sequencer.md
# inst_sequencer

Generates the 34-bit `inst` word stream that drives the systolic-array core: xmem→L0 weight transfer, kernel load, activation transfer, execute, then OFIFO drain into psum memory. It sits beside `core` and turns one `start` pulse into a complete single-tile convolution pass. It is the encoder counterpart of the instruction-field decode inside the core. Completion is reported with `done`.

## Interface
- `ADDR_W`, 11: xmem/pmem address width.
- `COL`, 8: weight words per tile, which is also the kernel-load length.
- `ACT_LEN`, 36: activation words per tile, which is also the execute and drain length.
- `LOAD_GAP`, 16: idle cycles after kernel load, letting weights settle in the PE array.
- `W_BASE`, 0: xmem base address of the weights.
- `A_BASE`, 64: xmem base address of the activations.
- `P_BASE`, 0: pmem base address of the results.

Ports:
- `clk` in 1: the single clock. All logic is on the rising edge.
- `reset` in 1: asynchronous, active-low.
- `start` in 1: one-cycle request. Only sampled in IDLE.
- `ofifo_valid` in 1: the core's OFIFO holds a readable psum row.
- `acc_mode` in 1: accumulate into pmem instead of overwriting. This port exists only with `INST_SEQ_ACC_EN`.
- `inst` out 34: instruction word, registered.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse at the end of the pass.

## Operation
Field map of `inst`:
- [33] acc
- [32] CEN_pmem, [31] WEN_pmem, [30:20] A_pmem
- [19] CEN_xmem, [18] WEN_xmem, [17:7] A_xmem
- [6] ofifo_rd, [5] ififo_wr, [4] ififo_rd
- [3] l0_rd, [2] l0_wr, [1] execute, [0] load

CEN and WEN are active-low. ififo_wr and ififo_rd are always 0.

- IDLE_WORD = 0x1_800C_0000: both SRAMs disabled, all strobes 0, addresses 0.

FSM states:
- **IDLE**: emits IDLE_WORD. `start` moves to W_L0. `start` is ignored in every other state.
- **W_L0**: reads weights into L0.
  - For k = 0..COL-1: CEN_xmem=0, WEN_xmem=1, A_xmem=W_BASE+k.
  - l0_wr=1 in the cycle after each read, because SRAM read latency is 1.
  - Lasts COL+1 cycles. The final cycle carries only l0_wr, with CEN_xmem=1.
- **W_LOAD**: l0_rd=1, load=1 for COL cycles.
- **W_GAP**: IDLE_WORD for LOAD_GAP cycles.
- **A_L0**: same as W_L0, but with A_BASE and ACT_LEN. Lasts ACT_LEN+1 cycles.
- **EXEC**: l0_rd=1, execute=1 for ACT_LEN cycles.
- **DRAIN**: moves OFIFO rows into pmem.
  - Each cycle with `ofifo_valid`=1 and reads issued < ACT_LEN: ofifo_rd=1.
  - The cycle after each read: CEN_pmem=0, WEN_pmem=0, A_pmem=P_BASE+i, acc=acc_mode (when enabled).
  - A read and the previous row's write may share one word.
  - Exits after the ACT_LEN-th pmem write.
- **DONE**: IDLE_WORD, `done`=1 for one cycle, then IDLE.

Counter and address rules:
- Counters are ADDR_W bits.
- Addresses wrap modulo 2^ADDR_W. No overflow error is raised.
- `ofifo_valid` low in DRAIN simply stalls. There is no timeout.

## Timing
- Reset values: `inst`=IDLE_WORD, `busy`=0, `done`=0, FSM in IDLE, all counters 0.
- `start` is sampled at edge t. The first W_L0 word appears after edge t+1, and `busy` rises at the same time.
- Every `inst` field is registered. No combinational path exists from `start` or `ofifo_valid` to `inst`.
- The ofifo_rd→pmem-write latency is exactly 1 cycle.
- Pass length is 2·COL + LOAD_GAP + 2·ACT_LEN + 3 + D, where D ≥ ACT_LEN+1 is the drain length.
- Reset asserted mid-pass: `inst` returns to IDLE_WORD immediately (asynchronously), with no `done`. A partial pmem write is not retried.
- A `start` coincident with `done` is ignored. A restart needs a new `start` while in IDLE.

## Configuration
- `INST_SEQ_ACC_EN` defined: the `acc_mode` port exists, and inst[33] = `acc_mode` on DRAIN pmem-write cycles.
- `INST_SEQ_ACC_EN` undefined: there is no `acc_mode` port, and inst[33] is constant 0.
- In both cases, inst[33]=0 in all non-write cycles.

## Structure
- Package `inst_seq_pkg`:
  - Field bit-position localparams.
  - IDLE_WORD.
  - The state enum (IDLE, W_L0, W_LOAD, W_GAP, A_L0, EXEC, DRAIN, DONE).
- Sub-module `xmem_l0_mover`:
  - Inputs: base, length, go.
  - Outputs: A_xmem, CEN_xmem, a delayed l0_wr, and last.
  - Instantiated once and shared by W_L0 and A_L0.

## Test plan
- **Reset**: hold `reset`=0 → `inst`=0x1_800C_0000, `busy`=0, `done`=0. Release with no start → `inst` stays IDLE_WORD.
- **Weight transfer (defaults, start at t)**:
  - Cycles t+1..t+8: A_xmem = 0..7, CEN_xmem=0.
  - Cycles t+2..t+9: l0_wr=1.
  - Next 8 cycles: load=1 and l0_rd=1.
  - Then 16 cycles of IDLE_WORD.
- **Activation and execute**:
  - A_xmem = 64..99.
  - 36 l0_wr pulses, then 36 consecutive execute=1 cycles.
  - execute never overlaps load.
- **Drain with stalls**: `ofifo_valid` toggles 1,0,1,0… → exactly 36 ofifo_rd, each followed next cycle by a pmem write at A_pmem 0..35. `done` pulses once, then `busy`=0.
- **Accumulate**: with `INST_SEQ_ACC_EN` and `acc_mode`=1 → inst[33]=1 on all 36 pmem-write cycles and 0 elsewhere. Without the macro → inst[33] is always 0.
- **Abort and ignored start**:
  - Reset asserted during EXEC → `inst`=IDLE_WORD within the same cycle, and no `done`.
  - `start` pulsed while `busy` → ignored, and the pass length is unchanged.
